// File: rtl/pcileech_com_rx_gearbox.sv
// pcileech_com_rx_gearbox: receive-path gearbox packing IN_W-bit PHY words into
// OUT_W = IN_W*RATIO FIFO words. After reset it waits INIT_DELAY cycles, emits the
// INIT_DEPTH-entry boot table, then packs live data (first word in the MS lane) and
// realigns lanes whenever two consecutive accepted words equal MAGIC.
// Optional feature macro: COM_RX_PARTIAL_TIMEOUT_EN (discard stale partial words).
module pcileech_com_rx_gearbox #(
    parameter int unsigned     IN_W            = 32,
    parameter int unsigned     RATIO           = 2,
    parameter logic [IN_W-1:0] MAGIC           = IN_W'(32'h66665555),
    parameter int unsigned     INIT_DEPTH      = 5,
    parameter int unsigned     INIT_DELAY      = 16,
    parameter int unsigned     PARTIAL_TIMEOUT = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_W-1:0]                    din,
    input  logic                               din_valid,
    output logic                               din_ready,
    input  logic [INIT_DEPTH*IN_W*RATIO-1:0]   init_table,
    output logic [IN_W*RATIO-1:0]              dout,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    output logic                               init_done,
    output logic [15:0]                        resync_count,
    output logic [15:0]                        timeout_count
);

    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned IDX_W  = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
    localparam int unsigned DLY_W  = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int unsigned TBL_N  = 1 << IDX_W;

    // Reject out-of-range configurations at elaboration time.
    if (IN_W < 8 || IN_W > 64 || RATIO < 2 || RATIO > 8 || INIT_DEPTH < 1 ||
        INIT_DEPTH > 16 || INIT_DELAY < 1 || PARTIAL_TIMEOUT < 1) begin : g_param_check
        $error("pcileech_com_rx_gearbox: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [DLY_W-1:0]   dly_cnt, dly_cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [LANE_W-1:0]  lane, lane_d;
    logic               prev_magic, prev_magic_d;
    logic [OUT_W-1:0]   shift_reg, shift_d;
    logic [OUT_W-1:0]   dout_d;
    logic               dout_valid_d;
    logic               init_done_d;
    logic [15:0]        resync_d;
    logic               accept;
    logic [OUT_W-1:0]   table_entry [TBL_N];

`ifdef COM_RX_PARTIAL_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(PARTIAL_TIMEOUT + 1);
    logic [IDLE_W-1:0]  idle_cnt, idle_d;
    logic [15:0]        timeout_d;
`endif

    // Boot table viewed as an array, padded to a power of two so idx never overruns.
    for (genvar g = 0; g < TBL_N; g++) begin : g_table
        if (g < INIT_DEPTH) begin : g_used
            assign table_entry[g] = init_table[g*OUT_W +: OUT_W];
        end else begin : g_pad
            assign table_entry[g] = '0;
        end
    end

    // Input is taken only while running and the output register can drain.
    assign din_ready = (state == S_RUN) & ~(dout_valid & ~dout_ready);
    assign accept    = din_valid & din_ready;

    // Next-state, boot-table sequencing, packing and resync decisions.
    always_comb begin
        state_d      = state;
        dly_cnt_d    = dly_cnt;
        idx_d        = idx;
        lane_d       = lane;
        prev_magic_d = prev_magic;
        shift_d      = shift_reg;
        dout_d       = dout;
        dout_valid_d = dout_valid & ~dout_ready;
        init_done_d  = init_done;
        resync_d     = resync_count;
`ifdef COM_RX_PARTIAL_TIMEOUT_EN
        idle_d       = idle_cnt;
        timeout_d    = timeout_count;
`endif
        case (state)
            S_WAIT: begin
                if (dly_cnt == DLY_W'(INIT_DELAY - 1)) begin
                    state_d      = S_INIT;
                    idx_d        = '0;
                    dout_d       = table_entry[0];
                    dout_valid_d = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt + DLY_W'(1);
                end
            end
            S_INIT: begin
                if (dout_ready) begin
                    if (idx == IDX_W'(INIT_DEPTH - 1)) begin
                        state_d      = S_RUN;
                        init_done_d  = 1'b1;
                        dout_valid_d = 1'b0;
                    end else begin
                        idx_d        = idx + IDX_W'(1);
                        dout_d       = table_entry[idx_d];
                        dout_valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    prev_magic_d = (din == MAGIC);
                    if (prev_magic && (din == MAGIC)) begin
                        lane_d = '0;
                        if (resync_count != 16'hFFFF) begin
                            resync_d = resync_count + 16'd1;
                        end
                    end else begin
                        shift_d = (shift_reg << IN_W) | OUT_W'(din);
                        if (lane == LANE_W'(RATIO - 1)) begin
                            lane_d       = '0;
                            dout_d       = shift_d;
                            dout_valid_d = 1'b1;
                        end else begin
                            lane_d = lane + LANE_W'(1);
                        end
                    end
                end
`ifdef COM_RX_PARTIAL_TIMEOUT_EN
                if (accept || (lane == '0)) begin
                    idle_d = '0;
                end else if (idle_cnt == IDLE_W'(PARTIAL_TIMEOUT - 1)) begin
                    idle_d       = '0;
                    lane_d       = '0;
                    prev_magic_d = 1'b0;
                    if (timeout_count != 16'hFFFF) begin
                        timeout_d = timeout_count + 16'd1;
                    end
                end else begin
                    idle_d = idle_cnt + IDLE_W'(1);
                end
`endif
            end
            default: state_d = S_WAIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and status registers; reset discards any held output or partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt      <= '0;
            idx          <= '0;
            lane         <= '0;
            prev_magic   <= 1'b0;
            shift_reg    <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            init_done    <= 1'b0;
            resync_count <= '0;
        end else begin
            dly_cnt      <= dly_cnt_d;
            idx          <= idx_d;
            lane         <= lane_d;
            prev_magic   <= prev_magic_d;
            shift_reg    <= shift_d;
            dout         <= dout_d;
            dout_valid   <= dout_valid_d;
            init_done    <= init_done_d;
            resync_count <= resync_d;
        end
    end

`ifdef COM_RX_PARTIAL_TIMEOUT_EN
    // Idle tracking for partially filled output words.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt      <= '0;
            timeout_count <= '0;
        end else begin
            idle_cnt      <= idle_d;
            timeout_count <= timeout_d;
        end
    end
`else
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pcileech_com_rx_gearbox.sv
// Bench for pcileech_com_rx_gearbox: boot-table timing, backpressure, packing and
// resync vectors, partial handling, mid-run reset and a randomized run against a
// word-queue reference model.
module tb_pcileech_com_rx_gearbox;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned RATIO = 2;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned DELAY = 16;
    localparam int unsigned PT    = 8;
    localparam logic [31:0] MAGIC = 32'h66665555;

    logic                       clk;
    logic                       rst;
    logic [IN_W-1:0]            din;
    logic                       din_valid;
    logic                       din_ready;
    logic [DEPTH-1:0][OUT_W-1:0] tbl;
    logic [OUT_W-1:0]           dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic                       init_done;
    logic [15:0]                resync_count;
    logic [15:0]                timeout_count;

    pcileech_com_rx_gearbox #(
        .PARTIAL_TIMEOUT(PT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .init_table   (tbl),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .init_done    (init_done),
        .resync_count (resync_count),
        .timeout_count(timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending words of the current output group, output register view.
    logic [31:0] m_group [$];
    logic [63:0] got_q [$];
    bit          m_prev, m_valid, run_mode;
    logic [63:0] m_dout;
    int          m_resync, m_tmo, m_idle;

    typedef struct {
        int                n;
        logic [7:0][31:0]  w;
        int                n_exp;
        logic [1:0][63:0]  e;
        int                d_res;
    } vec_t;

    vec_t vecs [4];
    int   exp_res_total;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_group();
        logic [63:0] r;
        r = '0;
        foreach (m_group[i]) r = (r << IN_W) | 64'(m_group[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_group.delete();
        got_q.delete();
        m_prev   = 1'b0;
        m_valid  = 1'b0;
        m_dout   = '0;
        m_resync = 0;
        m_tmo    = 0;
        m_idle   = 0;
    endtask

    // Called at a negedge with inputs set; checks the model just before the posedge,
    // advances the model by one cycle and returns at the next negedge.
    task automatic tick();
        bit acc, exp_rdy, nv;
        #2;
        if (run_mode) begin
            exp_rdy = !(m_valid && !dout_ready);
            check("din_ready", 64'(din_ready), 64'(exp_rdy));
            check("dout_valid", 64'(dout_valid), 64'(m_valid));
            if (m_valid) check("dout_held", dout, m_dout);
            acc = din_valid && exp_rdy;
            nv  = m_valid && !dout_ready;
            if (acc) begin
                if (din == MAGIC && m_prev) begin
                    m_group.delete();
                    m_resync++;
                end else begin
                    m_group.push_back(din);
                    if (m_group.size() == RATIO) begin
                        m_dout = pack_group();
                        nv     = 1'b1;
                        m_group.delete();
                    end
                end
                m_prev = (din == MAGIC);
            end
`ifdef COM_RX_PARTIAL_TIMEOUT_EN
            if (acc || m_group.size() == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == PT) begin
                    m_group.delete();
                    m_prev = 1'b0;
                    m_tmo++;
                    m_idle = 0;
                end
            end
`endif
            m_valid = nv;
        end
        if (dout_valid && dout_ready) got_q.push_back(dout);
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] w);
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Releases reset at a negedge and checks the boot-table timeline cycle by cycle.
    task automatic boot(input int stall);
        bit exp_v;
        int idx;
        rst = 1'b0;
        for (int k = 0; k <= 22 + stall; k++) begin
            dout_ready = !(k >= DELAY && k < DELAY + stall);
            din_valid  = (k < DELAY + DEPTH + stall);
            din        = 32'hBAD0_0000 | 32'(k);
            #1;
            exp_v = (k >= DELAY) && (k <= DELAY + DEPTH - 1 + stall);
            idx   = (k < DELAY + stall) ? 0 : k - DELAY - stall;
            check($sformatf("boot%0d valid c%0d", stall, k), 64'(dout_valid), 64'(exp_v));
            if (exp_v) check($sformatf("boot%0d dout c%0d", stall, k), dout, tbl[idx]);
            check($sformatf("boot%0d init_done c%0d", stall, k), 64'(init_done),
                  64'(k >= DELAY + DEPTH + stall));
            check($sformatf("boot%0d din_ready c%0d", stall, k), 64'(din_ready),
                  64'(k >= DELAY + DEPTH + stall));
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        model_reset();
        run_mode = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        run_mode   = 1'b0;
        tbl[0] = 64'h1000_0000_0000_0001;
        tbl[1] = 64'h2000_0000_0000_0002;
        tbl[2] = 64'h3000_0000_0000_0003;
        tbl[3] = 64'h4000_0000_0000_0004;
        tbl[4] = 64'h00000003_80182377;

        vecs[0].n = 2; vecs[0].w = '0; vecs[0].e = '0;
        vecs[0].w[0] = 32'hAAAA0001; vecs[0].w[1] = 32'hBBBB0002;
        vecs[0].n_exp = 1; vecs[0].e[0] = 64'hAAAA0001_BBBB0002; vecs[0].d_res = 0;
        vecs[1].n = 5; vecs[1].w = '0; vecs[1].e = '0;
        vecs[1].w[0] = 32'h12345678; vecs[1].w[1] = MAGIC; vecs[1].w[2] = MAGIC;
        vecs[1].w[3] = 32'h1; vecs[1].w[4] = 32'h2;
        vecs[1].n_exp = 2; vecs[1].e[0] = 64'h12345678_66665555;
        vecs[1].e[1] = 64'h00000001_00000002; vecs[1].d_res = 1;
        vecs[2].n = 6; vecs[2].w = '0; vecs[2].e = '0;
        vecs[2].w[0] = 32'h1; vecs[2].w[1] = MAGIC; vecs[2].w[2] = MAGIC;
        vecs[2].w[3] = MAGIC; vecs[2].w[4] = 32'h2; vecs[2].w[5] = 32'h3;
        vecs[2].n_exp = 2; vecs[2].e[0] = 64'h00000001_66665555;
        vecs[2].e[1] = 64'h00000002_00000003; vecs[2].d_res = 2;
        vecs[3].n = 2; vecs[3].w = '0; vecs[3].e = '0;
        vecs[3].w[0] = MAGIC; vecs[3].w[1] = 32'h5;
        vecs[3].n_exp = 1; vecs[3].e[0] = 64'h66665555_00000005; vecs[3].d_res = 0;

        @(negedge clk);
        tick();
        tick();
        check("rst dout_valid", 64'(dout_valid), 64'd0);
        check("rst dout", dout, 64'd0);
        check("rst din_ready", 64'(din_ready), 64'd0);
        check("rst init_done", 64'(init_done), 64'd0);
        check("rst resync_count", 64'(resync_count), 64'd0);
        check("rst timeout_count", 64'(timeout_count), 64'd0);

        boot(0);

        // Output appears one cycle after the last lane is accepted.
        din = 32'hAAAA0001; din_valid = 1'b1; tick();
        din = 32'hBBBB0002; tick();
        din_valid = 1'b0;
        #1;
        check("latency valid", 64'(dout_valid), 64'd1);
        check("latency dout", dout, 64'hAAAA0001_BBBB0002);
        tick();

        exp_res_total = 0;
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                din = vecs[v].w[i]; din_valid = 1'b1; dout_ready = 1'b1;
                tick();
            end
            din_valid = 1'b0;
            repeat (3) tick();
            check($sformatf("vec%0d count", v), 64'(got_q.size()), 64'(vecs[v].n_exp));
            for (int j = 0; j < vecs[v].n_exp; j++)
                check($sformatf("vec%0d out%0d", v, j),
                      (j < got_q.size()) ? got_q[j] : 64'hx, vecs[v].e[j]);
            exp_res_total += vecs[v].d_res;
            check($sformatf("vec%0d resync_count", v), 64'(resync_count), 64'(exp_res_total));
        end

        // Partial word followed by a long idle gap.
        got_q.delete();
        feed(32'h0000DEAD);
        repeat (PT) tick();
        feed(32'h1);
        feed(32'h2);
        repeat (3) tick();
        check("idle count", 64'(got_q.size()), 64'd1);
`ifdef COM_RX_PARTIAL_TIMEOUT_EN
        check("idle out", (got_q.size() > 0) ? got_q[0] : 64'hx, 64'h00000001_00000002);
        check("timeout_count", 64'(timeout_count), 64'd1);
`else
        check("idle out", (got_q.size() > 0) ? got_q[0] : 64'hx, 64'h0000DEAD_00000001);
        check("timeout_count", 64'(timeout_count), 64'd0);
        feed(32'h3);
        repeat (3) tick();
        check("idle flush", (got_q.size() > 1) ? got_q[1] : 64'hx, 64'h00000002_00000003);
`endif

        // Reset while a partial word is pending.
        feed(32'hA); feed(32'hB); feed(32'hC);
        tick();
        run_mode = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst dout_valid", 64'(dout_valid), 64'd0);
        check("midrst dout", dout, 64'd0);
        check("midrst din_ready", 64'(din_ready), 64'd0);
        check("midrst init_done", 64'(init_done), 64'd0);
        check("midrst resync_count", 64'(resync_count), 64'd0);
        check("midrst timeout_count", 64'(timeout_count), 64'd0);

        boot(10);
        feed(32'h7);
        feed(32'h8);
        repeat (2) tick();
        check("post-rst count", 64'(got_q.size()), 64'd1);
        check("post-rst out", (got_q.size() > 0) ? got_q[0] : 64'hx, 64'h00000007_00000008);

        // Randomized traffic with backpressure on both sides.
        for (int c = 0; c < 1500; c++) begin
            din        = ($urandom_range(0, 3) == 0) ? MAGIC : $urandom();
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (4) tick();
        check("rand resync_count", 64'(resync_count), 64'(m_resync));
        check("rand timeout_count", 64'(timeout_count), 64'(m_tmo));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
